// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, ALU decode and the EX/MEM pipeline register.
// The register output feeds back into the EX/MEM forwarding path for back-to-back dependencies.
module ex_mem_stage #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset_in,
    input  logic         stall_in,
    input  logic         flush_in,
    input  logic         RegWrite_in,
    input  logic         MemtoReg_in,
    input  logic         MemRead_in,
    input  logic         MemWrite_in,
    input  logic         RegDst_in,
    input  logic         ALU_Src_in,
    input  logic [1:0]   ALU_Op_in,
    input  logic [n-1:0] Read_Data_1_in,
    input  logic [n-1:0] Read_Data_2_in,
    input  logic [n-1:0] sign_extend_in,
    input  logic [4:0]   Rs_in,
    input  logic [4:0]   Rt_in,
    input  logic         MEM_WB_RegWrite_in,
    input  logic [4:0]   MEM_WB_Rd_in,
    input  logic [n-1:0] MEM_WB_Data_in,
    output logic         RegWrite_out,
    output logic         MemtoReg_out,
    output logic         MemRead_out,
    output logic         MemWrite_out,
    output logic [n-1:0] ALU_Result_out,
    output logic [n-1:0] Write_Data_out,
    output logic [4:0]   Rd_out,
    output logic         Zero_out,
    output logic         Overflow_out,
    output logic         Illegal_out
);

    logic         ex_hit_rs, ex_hit_rt, wb_hit_rs, wb_hit_rt;
    logic [n-1:0] fwd_rs, fwd_rt, op_a, op_b;
    logic [n-1:0] sum, diff, alu_result;
    logic         ovf_add, ovf_sub, alu_ovf, alu_illegal;
    logic [4:0]   shamt, rd_sel;
    logic [5:0]   funct;

    // Register 0 is hardwired, so a pending write to it is never a forwarding source.
    assign ex_hit_rs = RegWrite_out && (Rd_out != 5'd0) && (Rd_out == Rs_in);
    assign ex_hit_rt = RegWrite_out && (Rd_out != 5'd0) && (Rd_out == Rt_in);
    assign wb_hit_rs = MEM_WB_RegWrite_in && (MEM_WB_Rd_in != 5'd0) && (MEM_WB_Rd_in == Rs_in);
    assign wb_hit_rt = MEM_WB_RegWrite_in && (MEM_WB_Rd_in != 5'd0) && (MEM_WB_Rd_in == Rt_in);

    assign fwd_rs = ex_hit_rs ? ALU_Result_out : (wb_hit_rs ? MEM_WB_Data_in : Read_Data_1_in);
    assign fwd_rt = ex_hit_rt ? ALU_Result_out : (wb_hit_rt ? MEM_WB_Data_in : Read_Data_2_in);

    assign op_a = fwd_rs;
    assign op_b = ALU_Src_in ? sign_extend_in : fwd_rt;

    assign shamt  = sign_extend_in[10:6];
    assign funct  = sign_extend_in[5:0];
    assign rd_sel = RegDst_in ? sign_extend_in[15:11] : Rt_in;

    assign sum     = op_a + op_b;
    assign diff    = op_a - op_b;
    assign ovf_add = (op_a[n-1] == op_b[n-1]) && (sum[n-1] != op_a[n-1]);
    assign ovf_sub = (op_a[n-1] != op_b[n-1]) && (diff[n-1] != op_a[n-1]);

    always_comb begin
        alu_result  = '0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (ALU_Op_in)
            2'b00: begin
                alu_result = sum;
                alu_ovf    = ovf_add;
            end
            2'b01: begin
                alu_result = diff;
                alu_ovf    = ovf_sub;
            end
            2'b11: alu_result = op_a | op_b;
            default: begin
                case (funct)
                    6'b100000: begin
                        alu_result = sum;
                        alu_ovf    = ovf_add;
                    end
                    6'b100010: begin
                        alu_result = diff;
                        alu_ovf    = ovf_sub;
                    end
                    6'b100100: alu_result = op_a & op_b;
                    6'b100101: alu_result = op_a | op_b;
                    6'b100111: alu_result = ~(op_a | op_b);
                    6'b101010: alu_result = {{(n-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                    6'b000000: alu_result = op_b << shamt;
                    6'b000010: alu_result = op_b >> shamt;
                    default:   alu_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Flush beats stall so a bubble can be inserted while the stage is held.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            RegWrite_out   <= 1'b0;
            MemtoReg_out   <= 1'b0;
            MemRead_out    <= 1'b0;
            MemWrite_out   <= 1'b0;
            ALU_Result_out <= '0;
            Write_Data_out <= '0;
            Rd_out         <= 5'd0;
            Zero_out       <= 1'b0;
            Overflow_out   <= 1'b0;
            Illegal_out    <= 1'b0;
        end else if (flush_in) begin
            RegWrite_out   <= 1'b0;
            MemtoReg_out   <= 1'b0;
            MemRead_out    <= 1'b0;
            MemWrite_out   <= 1'b0;
            ALU_Result_out <= '0;
            Write_Data_out <= '0;
            Rd_out         <= 5'd0;
            Zero_out       <= 1'b0;
            Overflow_out   <= 1'b0;
            Illegal_out    <= 1'b0;
        end else if (!stall_in) begin
            RegWrite_out   <= RegWrite_in && !alu_ovf;
            MemtoReg_out   <= MemtoReg_in;
            MemRead_out    <= MemRead_in;
            MemWrite_out   <= MemWrite_in;
            ALU_Result_out <= alu_result;
            Write_Data_out <= fwd_rt;
            Rd_out         <= rd_sel;
            Zero_out       <= (alu_result == '0);
            Overflow_out   <= alu_ovf;
            Illegal_out    <= alu_illegal;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, ALU decode, forwarding, overflow, stall/flush, store path.
module tb_ex_mem_stage;

    localparam int n = 32;

    logic         clk;
    logic         reset_in;
    logic         stall_in, flush_in;
    logic         RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALU_Src_in;
    logic [1:0]   ALU_Op_in;
    logic [n-1:0] Read_Data_1_in, Read_Data_2_in, sign_extend_in;
    logic [4:0]   Rs_in, Rt_in;
    logic         MEM_WB_RegWrite_in;
    logic [4:0]   MEM_WB_Rd_in;
    logic [n-1:0] MEM_WB_Data_in;
    logic         RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
    logic [n-1:0] ALU_Result_out, Write_Data_out;
    logic [4:0]   Rd_out;
    logic         Zero_out, Overflow_out, Illegal_out;

    int checks = 0;
    int failures = 0;
    logic [n-1:0] exp_q[$];

    // Full output snapshot: flags, Rd, store data, result.
    logic [75:0] obs;
    assign obs = {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Zero_out,
                  Overflow_out, Illegal_out, Rd_out, Write_Data_out, ALU_Result_out};

    ex_mem_stage #(.n(n)) dut (
        .clk(clk), .reset_in(reset_in), .stall_in(stall_in), .flush_in(flush_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .RegDst_in(RegDst_in), .ALU_Src_in(ALU_Src_in),
        .ALU_Op_in(ALU_Op_in), .Read_Data_1_in(Read_Data_1_in), .Read_Data_2_in(Read_Data_2_in),
        .sign_extend_in(sign_extend_in), .Rs_in(Rs_in), .Rt_in(Rt_in),
        .MEM_WB_RegWrite_in(MEM_WB_RegWrite_in), .MEM_WB_Rd_in(MEM_WB_Rd_in),
        .MEM_WB_Data_in(MEM_WB_Data_in), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .ALU_Result_out(ALU_Result_out),
        .Write_Data_out(Write_Data_out), .Rd_out(Rd_out), .Zero_out(Zero_out),
        .Overflow_out(Overflow_out), .Illegal_out(Illegal_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [n-1:0] imm(input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        return {16'h0000, rd, sh, fn};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_in = 0; flush_in = 0;
        RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
        RegDst_in = 0; ALU_Src_in = 0; ALU_Op_in = 2'b00;
        Read_Data_1_in = '0; Read_Data_2_in = '0; sign_extend_in = '0;
        Rs_in = 0; Rt_in = 0;
        MEM_WB_RegWrite_in = 0; MEM_WB_Rd_in = 0; MEM_WB_Data_in = '0;
    endtask

    task automatic drive_alu(input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [n-1:0] a, input logic [n-1:0] b, input logic [n-1:0] se);
        ALU_Op_in = op; Rs_in = rs; Rt_in = rt;
        Read_Data_1_in = a; Read_Data_2_in = b; sign_extend_in = se;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_in = 1;
        #2 reset_in = 0;
        #1;
        checks++;
        if (obs !== 76'd0) begin
            failures++; $display("FAIL reset_assert obs=%h exp=0", obs);
        end
        step(); step();
        reset_in = 1;
        RegWrite_in = 1; RegDst_in = 1;
        drive_alu(2'b00, 5'd1, 5'd2, 32'd5, 32'd7, imm(5'd4, 5'd0, 6'd0));
        step();
        checks++;
        if (ALU_Result_out !== 32'd12 || RegWrite_out !== 1'b1 || Rd_out !== 5'd4) begin
            failures++; $display("FAIL add_5_7 res=%h rw=%b rd=%0d exp=c/1/4", ALU_Result_out, RegWrite_out, Rd_out);
        end
        #2 reset_in = 0;
        #1;
        checks++;
        if (obs !== 76'd0) begin
            failures++; $display("FAIL reset_midcycle obs=%h exp=0", obs);
        end
        #1 reset_in = 1;
        step();
        checks++;
        if (ALU_Result_out !== 32'd12 || RegWrite_out !== 1'b1) begin
            failures++; $display("FAIL reset_release res=%h rw=%b exp=c/1", ALU_Result_out, RegWrite_out);
        end
    endtask

    task automatic test_funct_sweep();
        logic [5:0] fn_tab [8];
        logic [4:0] sh_tab [8];
        logic [n-1:0] got;
        logic [n-1:0] want;
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000000, 6'b000010};
        sh_tab = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd1};
        exp_q.push_back(32'h16); exp_q.push_back(32'h2);  exp_q.push_back(32'h8);
        exp_q.push_back(32'hE);  exp_q.push_back(32'hFFFFFFF1); exp_q.push_back(32'h0);
        exp_q.push_back(32'hA0); exp_q.push_back(32'h5);
        clear_inputs();
        RegWrite_in = 1; RegDst_in = 1;
        for (int i = 0; i < 8; i++) begin
            drive_alu(2'b10, 5'd1, 5'd2, 32'hC, 32'hA, imm(5'd5, sh_tab[i], fn_tab[i]));
            step();
            got = ALU_Result_out;
            want = exp_q.pop_front();
            checks++;
            if (got !== want || Illegal_out !== 1'b0 || Rd_out !== 5'd5) begin
                failures++; $display("FAIL funct_%b res=%h ill=%b rd=%0d exp=%h/0/5", fn_tab[i], got, Illegal_out, Rd_out, want);
            end
        end
        drive_alu(2'b10, 5'd1, 5'd2, 32'hFFFFFFFF, 32'h1, imm(5'd5, 5'd0, 6'b101010));
        step();
        checks++;
        if (ALU_Result_out !== 32'd1) begin
            failures++; $display("FAIL slt_signed res=%h exp=1", ALU_Result_out);
        end
        drive_alu(2'b10, 5'd1, 5'd2, 32'hC, 32'hA, imm(5'd5, 5'd0, 6'b111111));
        step();
        checks++;
        if (ALU_Result_out !== 32'd0 || Illegal_out !== 1'b1 || Zero_out !== 1'b1) begin
            failures++; $display("FAIL illegal res=%h ill=%b z=%b exp=0/1/1", ALU_Result_out, Illegal_out, Zero_out);
        end
        drive_alu(2'b11, 5'd1, 5'd2, 32'hC, 32'hA, imm(5'd5, 5'd0, 6'b111111));
        step();
        checks++;
        if (ALU_Result_out !== 32'hE || Illegal_out !== 1'b0 || Zero_out !== 1'b0) begin
            failures++; $display("FAIL op11_or res=%h ill=%b z=%b exp=e/0/0", ALU_Result_out, Illegal_out, Zero_out);
        end
        drive_alu(2'b01, 5'd1, 5'd2, 32'h33, 32'h33, '0);
        step();
        checks++;
        if (ALU_Result_out !== 32'd0 || Zero_out !== 1'b1) begin
            failures++; $display("FAIL sub_zero res=%h z=%b exp=0/1", ALU_Result_out, Zero_out);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        RegWrite_in = 1; RegDst_in = 1;
        drive_alu(2'b00, 5'd1, 5'd2, 32'h80, 32'h80, imm(5'd3, 5'd0, 6'd0));
        step();
        checks++;
        if (ALU_Result_out !== 32'h100 || Rd_out !== 5'd3 || RegWrite_out !== 1'b1) begin
            failures++; $display("FAIL fwd_setup res=%h rd=%0d rw=%b exp=100/3/1", ALU_Result_out, Rd_out, RegWrite_out);
        end
        RegWrite_in = 0;
        MEM_WB_RegWrite_in = 1; MEM_WB_Rd_in = 5'd3; MEM_WB_Data_in = 32'h200;
        drive_alu(2'b00, 5'd3, 5'd0, 32'h111, 32'h0, imm(5'd4, 5'd0, 6'd0));
        step();
        checks++;
        if (ALU_Result_out !== 32'h100) begin
            failures++; $display("FAIL fwd_exmem_priority res=%h exp=100", ALU_Result_out);
        end
        step();
        checks++;
        if (ALU_Result_out !== 32'h200) begin
            failures++; $display("FAIL fwd_memwb res=%h exp=200", ALU_Result_out);
        end
        RegWrite_in = 1;
        MEM_WB_RegWrite_in = 0;
        drive_alu(2'b00, 5'd1, 5'd2, 32'h40, 32'h1, imm(5'd0, 5'd0, 6'd0));
        step();
        RegWrite_in = 0;
        MEM_WB_RegWrite_in = 1; MEM_WB_Rd_in = 5'd0; MEM_WB_Data_in = 32'h200;
        drive_alu(2'b00, 5'd0, 5'd0, 32'h55, 32'h0, imm(5'd6, 5'd0, 6'd0));
        step();
        checks++;
        if (ALU_Result_out !== 32'h55) begin
            failures++; $display("FAIL fwd_reg0 res=%h exp=55", ALU_Result_out);
        end
    endtask

    task automatic test_overflow();
        clear_inputs();
        RegWrite_in = 1; RegDst_in = 1;
        drive_alu(2'b00, 5'd1, 5'd2, 32'h7FFFFFFF, 32'h1, imm(5'd7, 5'd0, 6'd0));
        step();
        checks++;
        if (ALU_Result_out !== 32'h80000000 || Overflow_out !== 1'b1 || RegWrite_out !== 1'b0) begin
            failures++; $display("FAIL add_ovf res=%h ov=%b rw=%b exp=80000000/1/0", ALU_Result_out, Overflow_out, RegWrite_out);
        end
        drive_alu(2'b10, 5'd1, 5'd2, 32'h80000000, 32'h1, imm(5'd7, 5'd0, 6'b100010));
        step();
        checks++;
        if (ALU_Result_out !== 32'h7FFFFFFF || Overflow_out !== 1'b1 || RegWrite_out !== 1'b0) begin
            failures++; $display("FAIL sub_ovf res=%h ov=%b rw=%b exp=7fffffff/1/0", ALU_Result_out, Overflow_out, RegWrite_out);
        end
        drive_alu(2'b00, 5'd1, 5'd2, 32'h7FFFFFFE, 32'h1, imm(5'd7, 5'd0, 6'd0));
        step();
        checks++;
        if (ALU_Result_out !== 32'h7FFFFFFF || Overflow_out !== 1'b0 || RegWrite_out !== 1'b1) begin
            failures++; $display("FAIL add_no_ovf res=%h ov=%b rw=%b exp=7fffffff/0/1", ALU_Result_out, Overflow_out, RegWrite_out);
        end
    endtask

    task automatic test_stall_flush();
        logic [75:0] held;
        clear_inputs();
        RegWrite_in = 1; RegDst_in = 1; MemRead_in = 1; MemtoReg_in = 1;
        drive_alu(2'b00, 5'd1, 5'd2, 32'd5, 32'd7, imm(5'd6, 5'd0, 6'd0));
        step();
        held = {4'b1110, 3'b000, 5'd6, 32'd7, 32'd12};
        MemRead_in = 0; MemtoReg_in = 0; MemWrite_in = 1;
        drive_alu(2'b11, 5'd1, 5'd2, 32'hF0, 32'h0F, imm(5'd9, 5'd0, 6'd0));
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== held) begin
                failures++; $display("FAIL stall_hold_%0d obs=%h exp=%h", i, obs, held);
            end
        end
        flush_in = 1;
        step();
        checks++;
        if (obs !== 76'd0) begin
            failures++; $display("FAIL stall_flush obs=%h exp=0", obs);
        end
        flush_in = 0; stall_in = 0;
        step();
        checks++;
        if (obs !== {4'b1001, 3'b000, 5'd9, 32'h0F, 32'hFF}) begin
            failures++; $display("FAIL post_flush_load obs=%h exp=%h", obs, {4'b1001, 3'b000, 5'd9, 32'h0F, 32'hFF});
        end
    endtask

    task automatic test_store();
        clear_inputs();
        MemWrite_in = 1; ALU_Src_in = 1;
        MEM_WB_RegWrite_in = 1; MEM_WB_Rd_in = 5'd10; MEM_WB_Data_in = 32'hDEAD;
        drive_alu(2'b00, 5'd8, 5'd10, 32'h1000, 32'h1234, 32'd8);
        step();
        checks++;
        if (ALU_Result_out !== 32'h1008 || Write_Data_out !== 32'hDEAD || MemWrite_out !== 1'b1
            || RegWrite_out !== 1'b0 || Rd_out !== 5'd10) begin
            failures++; $display("FAIL store res=%h wd=%h mw=%b rw=%b rd=%0d exp=1008/dead/1/0/10",
                                 ALU_Result_out, Write_Data_out, MemWrite_out, RegWrite_out, Rd_out);
        end
    endtask

    initial begin
        test_reset();
        test_funct_sweep();
        test_forwarding();
        test_overflow();
        test_stall_flush();
        test_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register. Sits directly downstream of the ID/EX register and consumes its control, data and Rs/Rt outputs.
- Performs operand forwarding, ALU control decode, ALU operation and RegDst selection.
- Registers the results for the MEM stage, with stall (hold) and flush (bubble) support.

Parameters:
n, 32, datapath width

Ports:
clk  input  1  rising-edge clock
reset_in  input  1  asynchronous, active-low reset
stall_in  input  1  hold EX/MEM register contents
flush_in  input  1  load bubble into EX/MEM register
RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALU_Src_in  input  1 each  control fields from ID/EX
ALU_Op_in  input  2  ALU operation class from ID/EX
Read_Data_1_in, Read_Data_2_in  input  n  register-file operands from ID/EX
sign_extend_in  input  n  immediate; bits [15:11]=Rd, [10:6]=shamt, [5:0]=funct
Rs_in, Rt_in  input  5  source register numbers from ID/EX
MEM_WB_RegWrite_in  input  1  WB-stage write enable
MEM_WB_Rd_in  input  5  WB-stage destination register
MEM_WB_Data_in  input  n  WB-stage write-back value
RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out  output  1 each  registered control for MEM/WB
ALU_Result_out  output  n  registered ALU result
Write_Data_out  output  n  registered forwarded Rt value (store data)
Rd_out  output  5  registered destination register
Zero_out  output  1  registered (ALU result == 0)
Overflow_out  output  1  registered signed-overflow flag
Illegal_out  output  1  registered undefined-funct flag

Behaviour:
- Reset: while reset_in=0, all outputs are 0, asynchronously; this takes precedence over everything. Release is sampled at the next clk edge.
- Forwarding (combinational), computed identically for each source s in {Rs, Rt}:
  - Use the EX/MEM value (ALU_Result_out) if RegWrite_out=1, Rd_out!=0 and Rd_out==s.
  - Else use MEM_WB_Data_in if MEM_WB_RegWrite_in=1, MEM_WB_Rd_in!=0 and MEM_WB_Rd_in==s.
  - Else use Read_Data_1_in (for Rs) or Read_Data_2_in (for Rt).
  - EX/MEM has priority over MEM/WB.
- Operands: A = forwarded Rs. B = sign_extend_in if ALU_Src_in=1, else forwarded Rt.
- ALU decode:
  - ALU_Op 00: add.
  - ALU_Op 01: sub.
  - ALU_Op 11: or.
  - ALU_Op 10: decode funct:
    - 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed, result 0 or 1).
    - 000000 sll B by shamt; 000010 srl B by shamt (logical).
    - Any other funct: result 0, Illegal=1.
- Overflow: signed overflow on add/sub only (both ALU_Op paths). When overflow occurs, the registered RegWrite_out is forced to 0 and Overflow_out=1. The result is still registered.
- Destination: Rd = sign_extend_in[15:11] if RegDst_in=1, else Rt_in.
- Register update at posedge clk, priority flush > stall > load:
  - flush_in=1: all outputs 0 (bubble), regardless of stall_in.
  - stall_in=1: all outputs hold their values. The forwarding source (own outputs) is therefore stable.
  - Otherwise: load the computed values. Write_Data_out = forwarded Rt (not B).
- Latency: exactly 1 cycle from ID/EX inputs to outputs. Zero_out, Overflow_out and Illegal_out describe the same registered instruction; they are cleared by a bubble or load without the condition.
- Register 0: never forwarded from either stage. Rd_out=0 is allowed but is never a forwarding source.

Test Plan:
- Reset mid-operation: load add 5+7 (ALU_Op 00, ALU_Src 0), drop reset_in low between edges -> all outputs 0 immediately; first edge after release loads normally.
- R-type funct sweep, A=0x0000000C, B=0x0000000A:
  - add -> 0x16; sub -> 0x2; and -> 0x8; or -> 0xE; nor -> 0xFFFFFFF1; slt -> 0.
  - sll with shamt 4 -> 0xA0.
  - funct 111111 -> result 0, Illegal_out=1.
- Forwarding priority: prior instruction wrote Rd_out=3 with result 0x100; MEM_WB_Rd_in=3, MEM_WB_Data_in=0x200; Rs_in=3 -> A=0x100. With RegWrite_out=0, A=0x200. With Rs_in=0 and both stages targeting 0 -> Read_Data_1_in is used.
- Overflow: add 0x7FFFFFFF + 1 -> ALU_Result_out=0x80000000, Overflow_out=1, RegWrite_out=0 even though RegWrite_in=1.
- Stall/flush: stall_in=1 for 3 cycles -> outputs unchanged. stall_in=1 with flush_in=1 -> all outputs 0. Next normal cycle loads the new instruction.
- Store path: sw with ALU_Src 1, imm 8, Rs=0x1000, Rt forwarded from MEM/WB 0xDEAD -> ALU_Result_out=0x1008, Write_Data_out=0xDEAD, MemWrite_out=1.
